// File: rtl/block_position_register.sv
// block_position_register
//   Single-axis block coordinate for the tower game. The coordinate moves by
//   STEP on each rising edge of dec/inc and is kept inside [MIN_POS, MAX_POS].
//   A move is either instant or animated. An animated move slides the block
//   one pixel every TICK_DIV enabled cycles. The register also keeps a
//   saturating count of stacked levels.
//
// Ports
//   clk           system clock
//   resetn        synchronous reset, active low
//   enable        allows command accept and advances animated motion
//   dec / inc     level inputs; a rising edge requests -STEP / +STEP
//   anim          move mode sampled at accept: 0 instant, 1 animated
//   load          synchronous load of load_value, clamped to the bounds
//   load_value    value to load
//   curr_position current coordinate
//   level         net accepted dec commands, saturating
//   busy          animated move in progress
//   done          one-cycle pulse when a move completes
//   blocked       one-cycle pulse when a bound rejects a command
module block_position_register #(
  parameter int unsigned WIDTH    = 7,
  parameter int unsigned INIT     = 104,
  parameter int unsigned STEP     = 16,
  parameter int unsigned MIN_POS  = 0,
  parameter int unsigned MAX_POS  = 104,
  parameter int unsigned LEVEL_W  = 3,
  parameter int unsigned TICK_DIV = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               enable,
  input  logic               dec,
  input  logic               inc,
  input  logic               anim,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   curr_position,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               done,
  output logic               blocked
);

  localparam int unsigned W1     = WIDTH + 1;
  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [WIDTH-1:0]  INIT_W    = WIDTH'(INIT);
  localparam logic [WIDTH-1:0]  STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]  MIN_W     = WIDTH'(MIN_POS);
  localparam logic [WIDTH-1:0]  MAX_W     = WIDTH'(MAX_POS);
  localparam logic [WIDTH:0]    STEP_X    = W1'(STEP);
  localparam logic [WIDTH:0]    MIN_X     = W1'(MIN_POS);
  localparam logic [WIDTH:0]    MAX_X     = W1'(MAX_POS);
  localparam logic [WIDTH:0]    DEC_MIN_X = W1'(MIN_POS + STEP);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, MOVE_DN, MOVE_UP} state_t;

  state_t             state, state_n;
  logic               dec_q, inc_q;
  logic               rise_dec, rise_inc;
  logic [WIDTH-1:0]   target, target_n, pos_n;
  logic [WIDTH-1:0]   cmd_pos, step_pos;
  logic [WIDTH:0]     pos_x, load_x;
  logic [LEVEL_W-1:0] level_n;
  logic [TICK_W-1:0]  tick, tick_n;
  logic               busy_n, done_n, blocked_n;

  assign rise_dec = dec & ~dec_q;
  assign rise_inc = inc & ~inc_q;
  assign pos_x    = {1'b0, curr_position};
  assign load_x   = {1'b0, load_value};

  always_comb begin
    state_n   = state;
    pos_n     = curr_position;
    target_n  = target;
    level_n   = level;
    tick_n    = tick;
    busy_n    = busy;
    done_n    = 1'b0;
    blocked_n = 1'b0;
    cmd_pos   = curr_position;
    step_pos  = curr_position;

    if (load) begin
      // Load aborts any move silently; commands this cycle are dropped.
      if (load_x < MIN_X)      pos_n = MIN_W;
      else if (load_x > MAX_X) pos_n = MAX_W;
      else                     pos_n = load_value;
      level_n = '0;
      busy_n  = 1'b0;
      tick_n  = '0;
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // Simultaneous rises cancel out: no move, no blocked pulse.
          if (enable && (rise_dec ^ rise_inc)) begin
            if ((rise_dec && pos_x < DEC_MIN_X) ||
                (rise_inc && (pos_x + STEP_X) > MAX_X)) begin
              blocked_n = 1'b1;
            end else begin
              if (rise_dec) begin
                cmd_pos = curr_position - STEP_W;
                if (level != '1) level_n = level + 1'b1;
              end else begin
                cmd_pos = curr_position + STEP_W;
                if (level != '0) level_n = level - 1'b1;
              end
              if (anim) begin
                target_n = cmd_pos;
                busy_n   = 1'b1;
                tick_n   = '0;
                state_n  = rise_dec ? MOVE_DN : MOVE_UP;
              end else begin
                pos_n  = cmd_pos;
                done_n = 1'b1;
              end
            end
          end
        end
        MOVE_DN, MOVE_UP: begin
          if (enable) begin
            if (tick == TICK_LAST) begin
              tick_n   = '0;
              step_pos = (state == MOVE_DN) ? curr_position - 1'b1
                                            : curr_position + 1'b1;
              pos_n    = step_pos;
              if (step_pos == target) begin
                busy_n  = 1'b0;
                done_n  = 1'b1;
                state_n = IDLE;
              end
            end else begin
              tick_n = tick + 1'b1;
            end
          end
        end
        default: begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // Edge detectors keep sampling through reset so a held line does not
    // look like a fresh edge on release.
    dec_q <= dec;
    inc_q <= inc;
    if (!resetn) begin
      state         <= IDLE;
      curr_position <= INIT_W;
      target        <= INIT_W;
      level         <= '0;
      tick          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      blocked       <= 1'b0;
    end else begin
      state         <= state_n;
      curr_position <= pos_n;
      target        <= target_n;
      level         <= level_n;
      tick          <= tick_n;
      busy          <= busy_n;
      done          <= done_n;
      blocked       <= blocked_n;
    end
  end

endmodule

// File: tb/tb_block_position_register.sv
// tb_block_position_register
//   Drives block_position_register through the directed scenarios and then a
//   randomized phase. Every cycle is compared against a behavioural model that
//   tracks position as start + direction * (enabled cycles / TICK_DIV).
module tb_block_position_register;

  localparam int WIDTH    = 7;
  localparam int INIT     = 104;
  localparam int STEP     = 16;
  localparam int MIN_POS  = 0;
  localparam int MAX_POS  = 104;
  localparam int LEVEL_W  = 3;
  localparam int TICK_DIV = 2;
  localparam int LVL_MAX  = (1 << LEVEL_W) - 1;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic               enable = 1'b0;
  logic               dec = 1'b0;
  logic               inc = 1'b0;
  logic               anim = 1'b0;
  logic               load = 1'b0;
  logic [WIDTH-1:0]   load_value = '0;
  logic [WIDTH-1:0]   curr_position;
  logic [LEVEL_W-1:0] level;
  logic               busy, done, blocked;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pos = INIT, m_level = 0, m_busy = 0, m_done = 0, m_blocked = 0;
  int m_start = 0, m_dir = 0, m_elapsed = 0;
  int m_dprev = 0, m_iprev = 0;

  block_position_register #(
    .WIDTH(WIDTH), .INIT(INIT), .STEP(STEP), .MIN_POS(MIN_POS),
    .MAX_POS(MAX_POS), .LEVEL_W(LEVEL_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .dec(dec), .inc(inc),
    .anim(anim), .load(load), .load_value(load_value),
    .curr_position(curr_position), .level(level), .busy(busy),
    .done(done), .blocked(blocked)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic model_step();
    int rd, ri, tgt;
    rd = (dec && !m_dprev) ? 1 : 0;
    ri = (inc && !m_iprev) ? 1 : 0;
    m_dprev = int'(dec);
    m_iprev = int'(inc);
    m_done = 0;
    m_blocked = 0;
    if (!resetn) begin
      m_pos = INIT; m_level = 0; m_busy = 0;
      return;
    end
    if (load) begin
      m_pos = (int'(load_value) > MAX_POS) ? MAX_POS :
              (int'(load_value) < MIN_POS) ? MIN_POS : int'(load_value);
      m_level = 0; m_busy = 0;
      return;
    end
    if (m_busy != 0) begin
      if (enable) begin
        m_elapsed++;
        m_pos = m_start + m_dir * (m_elapsed / TICK_DIV);
        if (m_elapsed == STEP * TICK_DIV) begin
          m_busy = 0; m_done = 1;
        end
      end
      return;
    end
    if (!enable || rd == ri) return;
    tgt = (rd != 0) ? m_pos - STEP : m_pos + STEP;
    if (tgt < MIN_POS || tgt > MAX_POS) begin
      m_blocked = 1;
      return;
    end
    if (rd != 0) m_level = (m_level < LVL_MAX) ? m_level + 1 : LVL_MAX;
    else         m_level = (m_level > 0) ? m_level - 1 : 0;
    if (anim) begin
      m_busy = 1; m_start = m_pos; m_dir = (rd != 0) ? -1 : 1; m_elapsed = 0;
    end else begin
      m_pos = tgt; m_done = 1;
    end
  endtask

  // One clock: inputs already set, model advanced at the edge, outputs
  // compared 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_eq("position", int'(curr_position), m_pos);
    check_eq("level",    int'(level),         m_level);
    check_eq("busy",     int'(busy),          m_busy);
    check_eq("done",     int'(done),          m_done);
    check_eq("blocked",  int'(blocked),       m_blocked);
    check_eq("done_and_blocked", int'(done & blocked), 0);
  endtask

  task automatic do_load(input int value);
    load = 1'b1; load_value = WIDTH'(value);
    cyc();
    load = 1'b0;
  endtask

  initial begin
    int dones, blocks, busy_cycles, n;

    // Reset with dec held high through release.
    resetn = 1'b0; dec = 1'b1; enable = 1'b1;
    repeat (3) cyc();
    resetn = 1'b1;
    repeat (3) cyc();
    check_eq("reset_hold_pos", int'(curr_position), 104);
    check_eq("reset_hold_level", int'(level), 0);
    dec = 1'b0;
    cyc();

    // Instant mode: six accepted dec pulses, then one blocked.
    anim = 1'b0; dones = 0; blocks = 0;
    for (int i = 1; i <= 7; i++) begin
      dec = 1'b1; cyc();
      dones += int'(done); blocks += int'(blocked);
      dec = 1'b0; cyc();
      dones += int'(done); blocks += int'(blocked);
      if (i <= 6) check_eq("instant_pos", int'(curr_position), 104 - 16 * i);
    end
    check_eq("instant_final_pos", int'(curr_position), 8);
    check_eq("instant_level", int'(level), 6);
    check_eq("instant_dones", dones, 6);
    check_eq("instant_blocks", blocks, 1);

    // Animated dec with an ignored mid-move dec pulse.
    do_load(104);
    anim = 1'b1; dec = 1'b1; cyc(); dec = 1'b0;
    busy_cycles = int'(busy); dones = 0; n = 0;
    while (busy && n < 200) begin
      dec = (n == 6) ? 1'b1 : 1'b0;
      cyc(); n++;
      busy_cycles += int'(busy); dones += int'(done);
    end
    dec = 1'b0;
    check_eq("anim_busy_cycles", busy_cycles, 32);
    check_eq("anim_final_pos", int'(curr_position), 88);
    check_eq("anim_level", int'(level), 1);
    check_eq("anim_dones", dones, 1);

    // Animated dec with a 10-cycle enable gap.
    do_load(104);
    cyc();
    dec = 1'b1; cyc(); dec = 1'b0;
    busy_cycles = int'(busy); n = 0;
    while (busy && n < 200) begin
      enable = (n >= 8 && n < 18) ? 1'b0 : 1'b1;
      cyc(); n++;
      busy_cycles += int'(busy);
    end
    enable = 1'b1;
    check_eq("gap_busy_cycles", busy_cycles, 42);
    check_eq("gap_final_pos", int'(curr_position), 88);

    // inc at the bottom bound, then simultaneous dec/inc.
    do_load(104);
    anim = 1'b0;
    inc = 1'b1; cyc();
    check_eq("inc_bound_blocked", int'(blocked), 1);
    check_eq("inc_bound_pos", int'(curr_position), 104);
    inc = 1'b0; cyc();
    dec = 1'b1; inc = 1'b1; cyc();
    check_eq("both_blocked", int'(blocked), 0);
    check_eq("both_pos", int'(curr_position), 104);
    dec = 1'b0; inc = 1'b0; cyc();

    // Load during an animated move aborts it.
    anim = 1'b1; dec = 1'b1; cyc(); dec = 1'b0;
    repeat (9) cyc();
    do_load(120);
    check_eq("load_clamp_pos", int'(curr_position), 104);
    check_eq("load_busy", int'(busy), 0);
    check_eq("load_level", int'(level), 0);
    check_eq("load_done", int'(done), 0);
    repeat (3) cyc();

    // Randomized phase.
    for (int i = 0; i < 4000; i++) begin
      resetn     = ($urandom_range(0, 299) != 0);
      enable     = ($urandom_range(0, 7) != 0);
      dec        = ($urandom_range(0, 2) == 0);
      inc        = ($urandom_range(0, 3) == 0);
      anim       = ($urandom_range(0, 1) == 1);
      load       = ($urandom_range(0, 59) == 0);
      load_value = WIDTH'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
